// File: rtl/systola_pkg.sv
// Shared constants and types for the systolic array result path.
package systola_pkg;

    localparam int ACC_W  = 12;
    localparam int DATA_W = 8;

    typedef enum logic {
        IDLE,
        STREAM
    } drain_state_t;

endpackage

// File: rtl/pe_requant.sv
// Requantises a signed 12-bit accumulator to signed 8 bits:
// optional ReLU, round-half-up right shift, then saturation.
module pe_requant
    import systola_pkg::*;
(
    input  logic [ACC_W-1:0]  raw,
    input  logic [2:0]        shift,
    input  logic              relu_en,
    output logic [DATA_W-1:0] data
);

    localparam logic signed [ACC_W:0] SAT_MAX = $signed((ACC_W+1)'(127));
    localparam logic signed [ACC_W:0] SAT_MIN = $signed((ACC_W+1)'(-128));

    logic signed [ACC_W:0] v_ext;
    logic signed [ACC_W:0] v_rnd;
    logic signed [ACC_W:0] v_shr;

    // One extra bit of headroom so the rounding add on +2047 cannot wrap.
    always_comb begin
        v_ext = $signed({raw[ACC_W-1], raw});
        if (relu_en && raw[ACC_W-1]) begin
            v_ext = '0;
        end
        v_rnd = v_ext;
        if (shift != 3'd0) begin
            v_rnd = v_ext + $signed((ACC_W+1)'(1) << (shift - 3'd1));
        end
        v_shr = v_rnd >>> shift;
        if (v_shr > SAT_MAX) begin
            data = 8'h7F;
        end else if (v_shr < SAT_MIN) begin
            data = 8'h80;
        end else begin
            data = v_shr[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/pe_drain.sv
// Snapshots the PE array results on capture and streams them out in row-major
// order over valid/ready, each beat carrying the raw and requantised value.
module pe_drain
    import systola_pkg::*;
#(
    parameter  int ROWS = 4,
    parameter  int COLS = 4,
    localparam int N    = ROWS * COLS,
    localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              capture,
    input  logic [ACC_W-1:0]  outs [0:N-1],
    input  logic [2:0]        shift,
    input  logic              relu_en,
    output logic              busy,
    output logic              cap_drop,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ACC_W-1:0]  m_raw,
    output logic [IW-1:0]     m_idx,
    output logic              m_last
);

    drain_state_t     state_reg;
    logic [IW-1:0]    idx_reg;
    logic [2:0]       shift_reg;
    logic             relu_reg;
    logic             cap_drop_reg;
    logic [ACC_W-1:0] bank_q [0:N-1];

    logic handshake;
    logic at_last;
    logic final_hs;
    logic load;

    assign handshake = (state_reg == STREAM) && m_ready;
    assign at_last   = (idx_reg == IW'(N - 1));
    assign final_hs  = handshake && at_last;
    // A capture coinciding with the final handshake starts the next tile without a bubble.
    assign load      = capture && ((state_reg == IDLE) || final_hs);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bank
            logic [ACC_W-1:0] val_reg;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    val_reg <= '0;
                end else if (load) begin
                    val_reg <= outs[gi];
                end
            end
            assign bank_q[gi] = val_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            shift_reg    <= '0;
            relu_reg     <= 1'b0;
            cap_drop_reg <= 1'b0;
        end else begin
            cap_drop_reg <= capture && (state_reg == STREAM) && !final_hs;
            if (load) begin
                state_reg <= STREAM;
                idx_reg   <= '0;
                shift_reg <= shift;
                relu_reg  <= relu_en;
            end else if (handshake) begin
                if (at_last) begin
                    state_reg <= IDLE;
                    idx_reg   <= '0;
                end else begin
                    idx_reg <= idx_reg + IW'(1);
                end
            end
        end
    end

    assign busy     = (state_reg == STREAM);
    assign m_valid  = busy;
    assign cap_drop = cap_drop_reg;
    assign m_idx    = idx_reg;
    assign m_last   = busy && at_last;
    assign m_raw    = bank_q[idx_reg];

    pe_requant u_requant (
        .raw     (m_raw),
        .shift   (shift_reg),
        .relu_en (relu_reg),
        .data    (m_data)
    );

endmodule

// File: tb/tb_pe_drain.sv
// Directed bench for pe_drain: drain order, requant arithmetic, backpressure,
// dropped capture, back-to-back tiles and asynchronous reset mid-stream.
module tb_pe_drain;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        capture = 1'b0;
    logic [11:0] outs [0:N-1];
    logic [2:0]  shift = 3'd0;
    logic        relu_en = 1'b0;
    logic        busy;
    logic        cap_drop;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;
    logic [11:0] m_raw;
    logic [3:0]  m_idx;
    logic        m_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pe_drain #(.ROWS(4), .COLS(4)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .capture  (capture),
        .outs     (outs),
        .shift    (shift),
        .relu_en  (relu_en),
        .busy     (busy),
        .cap_drop (cap_drop),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_raw    (m_raw),
        .m_idx    (m_idx),
        .m_last   (m_last)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_beat(string tag, int k, logic [11:0] raw, logic [7:0] data);
        check({tag, "_valid"}, 32'(m_valid), 32'd1);
        check({tag, "_idx"}, 32'(m_idx), 32'(k));
        check({tag, "_raw"}, 32'(m_raw), 32'(raw));
        check({tag, "_data"}, 32'(m_data), 32'(data));
        check({tag, "_last"}, 32'(m_last), 32'(k == N - 1));
        $display("%s beat idx=%0d raw=%03h data=%02h", tag, m_idx, m_raw, m_data);
    endtask

    task automatic do_capture(logic [2:0] sh, logic relu);
        shift   = sh;
        relu_en = relu;
        capture = 1'b1;
        cyc();
        capture = 1'b0;
    endtask

    task automatic check_idle(string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_valid"}, 32'(m_valid), 32'd0);
    endtask

    // Requant table: raw inputs in slots 0..3, expected data per (shift, relu) case
    logic [11:0] rq_raw [0:3] = '{12'h7FF, 12'hFFB, 12'h800, 12'h064};
    logic [2:0]  rq_sh  [0:3] = '{3'd2, 3'd1, 3'd1, 3'd0};
    logic        rq_rl  [0:3] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0]  rq_exp [0:3][0:3] = '{
        '{8'h7F, 8'hFF, 8'h80, 8'h19},
        '{8'h7F, 8'hFE, 8'h80, 8'h32},
        '{8'h7F, 8'h00, 8'h00, 8'h32},
        '{8'h7F, 8'hFB, 8'h80, 8'h64}
    };

    logic [15:0] ready_pat = 16'b1011_0010_1110_0101;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < N; k++) outs[k] = 12'(k);

        // Reset state
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cap_drop", 32'(cap_drop), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_raw", 32'(m_raw), 32'd0);
        check("rst_idx", 32'(m_idx), 32'd0);
        check("rst_last", 32'(m_last), 32'd0);
        rstn = 1'b1;
        cyc();
        cyc();
        check_idle("pre_cap");

        // Basic drain, no stall
        m_ready = 1'b1;
        do_capture(3'd0, 1'b0);
        for (int k = 0; k < N; k++) begin
            expect_beat("basic", k, 12'(k), 8'(k));
            check("basic_busy", 32'(busy), 32'd1);
            cyc();
        end
        check_idle("basic_end");

        // Requant arithmetic
        for (int k = 0; k < N; k++) outs[k] = (k < 4) ? rq_raw[k] : 12'h000;
        for (int t = 0; t < 4; t++) begin
            do_capture(rq_sh[t], rq_rl[t]);
            for (int k = 0; k < N; k++) begin
                expect_beat($sformatf("rq%0d", t), k, outs[k], (k < 4) ? rq_exp[t][k] : 8'h00);
                cyc();
            end
            check_idle("rq_end");
        end

        // Backpressure with a fixed irregular ready pattern
        for (int k = 0; k < N; k++) outs[k] = 12'(3 * k + 1);
        m_ready = 1'b0;
        do_capture(3'd0, 1'b0);
        begin
            int k = 0;
            int n = 0;
            while (k < N && n < 200) begin
                check("bp_valid", 32'(m_valid), 32'd1);
                check("bp_idx", 32'(m_idx), 32'(k));
                check("bp_raw", 32'(m_raw), 32'(3 * k + 1));
                check("bp_data", 32'(m_data), 32'(3 * k + 1));
                m_ready = ready_pat[n % 16];
                if (m_ready) $display("bp beat idx=%0d raw=%03h", m_idx, m_raw);
                cyc();
                if (m_ready) k++;
                n++;
            end
            check("bp_all_beats", 32'(k), 32'(N));
        end
        m_ready = 1'b0;
        check_idle("bp_end");

        // Capture during STREAM (not the final beat) is dropped
        for (int k = 0; k < N; k++) outs[k] = 12'(k + 16);
        m_ready = 1'b1;
        do_capture(3'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            expect_beat("drop", k, 12'(k + 16), 8'(k + 16));
            cyc();
        end
        for (int k = 0; k < N; k++) outs[k] = 12'h0AA;
        m_ready = 1'b0;
        capture = 1'b1;
        cyc();
        capture = 1'b0;
        check("drop_pulse", 32'(cap_drop), 32'd1);
        check("drop_idx_hold", 32'(m_idx), 32'd5);
        cyc();
        check("drop_pulse_end", 32'(cap_drop), 32'd0);
        m_ready = 1'b1;
        for (int k = 5; k < N; k++) begin
            expect_beat("drop", k, 12'(k + 16), 8'(k + 16));
            cyc();
        end
        check_idle("drop_end");

        // Back-to-back tiles: capture on the final handshake
        for (int k = 0; k < N; k++) outs[k] = 12'(k);
        do_capture(3'd0, 1'b0);
        for (int k = 0; k < N - 1; k++) cyc();
        expect_beat("b2b_a", N - 1, 12'(N - 1), 8'(N - 1));
        for (int k = 0; k < N; k++) outs[k] = 12'(k + 100);
        capture = 1'b1;
        cyc();
        capture = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_no_drop", 32'(cap_drop), 32'd0);
        for (int k = 0; k < N; k++) begin
            expect_beat("b2b_b", k, 12'(k + 100), 8'(k + 100));
            cyc();
        end
        check_idle("b2b_end");

        // Asynchronous reset mid-stream
        for (int k = 0; k < N; k++) outs[k] = 12'(k + 1);
        do_capture(3'd0, 1'b0);
        for (int k = 0; k < 7; k++) cyc();
        expect_beat("rstm", 7, 12'd8, 8'd8);
        #2;
        rstn = 1'b0;
        #1;
        check("rstm_busy", 32'(busy), 32'd0);
        check("rstm_valid", 32'(m_valid), 32'd0);
        check("rstm_idx", 32'(m_idx), 32'd0);
        check("rstm_raw", 32'(m_raw), 32'd0);
        check("rstm_data", 32'(m_data), 32'd0);
        check("rstm_last", 32'(m_last), 32'd0);
        cyc();
        rstn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check_idle("rstm_after");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
